// File: rtl/converter.sv
// converter: single-precision (binary32) floating-point adder/subtractor.
// Subtraction is performed by presenting B with its sign bit inverted.
// Denormal inputs are flushed to signed zero; rounding is round-to-nearest-even.
// The whole datapath is combinational ahead of a single output register bank,
// so results appear one clock after their operands are sampled.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (clears all outputs)
//   A, B      binary32 operands, sampled every rising edge
//   result    registered A+B, binary32
//   overflow  registered; sum rounded to infinity
//   underflow registered; nonzero sum flushed to zero
//   exception registered; NaN input or Inf + -Inf
module converter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        sa, sb, sl;
  logic [7:0]  ea, eb, el, es, diff;
  logic [23:0] ma, mb, ml, ms;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [26:0] ext_s, lost_mask, aligned, dif, mant;
  logic [27:0] sum;
  logic [4:0]  lzc;
  logic        cancel, round_up;
  logic [24:0] rnd;
  logic [22:0] frac;
  logic signed [9:0] exp_w;

  logic [31:0] result_n;
  logic        overflow_n, underflow_n, exception_n;

  always_comb begin
    // Unpack; exp==0 flushes the significand to zero
    sa     = A[31];
    sb     = B[31];
    ea     = A[30:23];
    eb     = B[30:23];
    ma     = (ea != 8'd0) ? {1'b1, A[22:0]} : 24'd0;
    mb     = (eb != 8'd0) ? {1'b1, B[22:0]} : 24'd0;
    a_nan  = (ea == 8'hFF) && (A[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (B[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (A[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (B[22:0] == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);

    // Larger magnitude first
    swap = {eb, mb} > {ea, ma};
    sl   = swap ? sb : sa;
    el   = swap ? eb : ea;
    es   = swap ? ea : eb;
    ml   = swap ? mb : ma;
    ms   = swap ? ma : mb;
    diff = el - es;

    // Align smaller significand with guard/round/sticky
    ext_s     = {ms, 3'b000};
    lost_mask = '0;
    if (diff >= 8'd26) begin
      aligned = (ms != 24'd0) ? 27'd1 : 27'd0;
    end else begin
      aligned   = ext_s >> diff;
      lost_mask = (27'd1 << diff) - 27'd1;
      if ((ext_s & lost_mask) != 27'd0) aligned[0] = 1'b1;
    end

    sum    = '0;
    dif    = '0;
    lzc    = '0;
    cancel = 1'b0;
    exp_w  = $signed({2'b00, el});
    if (sa == sb) begin
      sum = {1'b0, ml, 3'b000} + {1'b0, aligned};
      if (sum[27]) begin
        mant  = {sum[27:2], sum[1] | sum[0]};
        exp_w = exp_w + 10'sd1;
      end else begin
        mant = sum[26:0];
      end
    end else begin
      dif    = {ml, 3'b000} - aligned;
      cancel = (dif == 27'd0);
      // Highest set bit wins since the scan runs upward
      for (int unsigned i = 0; i < 27; i++) begin
        if (dif[i]) lzc = 5'(26 - i);
      end
      // A left shift of 2+ only happens when alignment shifted by <= 1,
      // so the sticky bit is zero and the shift is exact
      mant  = dif << lzc;
      exp_w = exp_w - $signed({5'b00000, lzc});
    end

    // Round to nearest even; a mantissa carry renormalizes
    round_up = mant[2] & (mant[1] | mant[0] | mant[3]);
    rnd      = {1'b0, mant[26:3]} + {24'd0, round_up};
    if (rnd[24]) begin
      frac  = rnd[23:1];
      exp_w = exp_w + 10'sd1;
    end else begin
      frac = rnd[22:0];
    end

    result_n    = '0;
    overflow_n  = 1'b0;
    underflow_n = 1'b0;
    exception_n = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      result_n    = QNAN;
      exception_n = 1'b1;
    end else if (a_inf) begin
      result_n = A;
    end else if (b_inf) begin
      result_n = B;
    end else if (a_zero && b_zero) begin
      result_n = {sa & sb, 31'd0};
    end else if (a_zero) begin
      result_n = B;
    end else if (b_zero) begin
      result_n = A;
    end else if (cancel) begin
      result_n = '0;
    end else if (exp_w >= 10'sd255) begin
      result_n   = {sl, 8'hFF, 23'd0};
      overflow_n = 1'b1;
    end else if (exp_w <= 10'sd0) begin
      result_n    = {sl, 31'd0};
      underflow_n = 1'b1;
    end else begin
      result_n = {sl, exp_w[7:0], frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else begin
      result    <= result_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
      exception <= exception_n;
    end
  end

endmodule

// File: tb/tb_converter.sv
// Directed testbench for converter: each step drives an operand pair, waits
// one rising edge and checks the registered result and flags.
module tb_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [31:0] result;
  logic        overflow, underflow, exception;

  int compared   = 0;
  int mismatched = 0;

  converter #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .exception (exception)
  );

  always #5 clk = ~clk;

  // flags ordered {overflow, underflow, exception}
  task automatic check(input string tag, input logic [31:0] er, input logic [2:0] ef);
    compared++;
    assert (result === er) else begin
      mismatched++;
      $error("FAIL %s result: got %h expected %h", tag, result, er);
    end
    compared++;
    assert ({overflow, underflow, exception} === ef) else begin
      mismatched++;
      $error("FAIL %s flags(ov,un,ex): got %b expected %b", tag, {overflow, underflow, exception}, ef);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic [2:0] ef);
    A = a;
    B = b;
    @(posedge clk);
    #1;
    check(tag, er, ef);
  endtask

  initial begin
    rst = 1'b1;
    A   = 32'h3F80_0000;
    B   = 32'h3F80_0000;
    #3;
    check("reset_initial", 32'h0000_0000, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // Consecutive edges: every result lands one cycle after its operands
    step("add_carry_3.2+4.2",  32'h404C_CCCC, 32'h4086_6666, 32'h40EC_CCCC, 3'b000);

    // Asynchronous reset mid-cycle with nonzero outputs
    A = 32'h4171_999A;
    B = 32'h4013_3333;
    #1;
    rst = 1'b1;
    #1;
    check("reset_async", 32'h0000_0000, 3'b000);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_15.1+2.3", 32'h418B_3333, 3'b000);

    step("sub_-0.5+6.4",       32'hBF00_0000, 32'h40CC_CCCC, 32'h40BC_CCCC, 3'b000);
    step("two_negatives_tie",  32'hC28C_3EFA, 32'hC1F1_999A, 32'hC2C8_A560, 3'b000);
    step("mixed_norm_tie_up",  32'h4034_B4B5, 32'hBF70_F0F1, 32'h3FF0_F0F2, 3'b000);
    step("cancel_pi",          32'h4049_0FDB, 32'hC049_0FDB, 32'h0000_0000, 3'b000);
    step("neg0+neg0",          32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3'b000);
    step("pos0+neg0",          32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 3'b000);
    step("overflow_max+max",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3'b100);
    step("inf_minus_inf",      32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 3'b001);
    step("nan_input",          32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b001);
    step("nan_on_b",           32'h3F80_0000, 32'hFF80_0001, 32'h7FC0_0000, 3'b001);
    step("underflow_flush",    32'h0080_0001, 32'h8080_0000, 32'h0000_0000, 3'b010);
    step("neginf+finite",      32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 3'b000);
    step("inf+inf_same",       32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, 3'b000);
    step("zero+x_exact",       32'h0000_0000, 32'h3F80_0001, 32'h3F80_0001, 3'b000);
    step("denorm+x_flush",     32'h0000_0001, 32'hC000_0000, 32'hC000_0000, 3'b000);
    step("round_carry_renorm", 32'h3F7F_FFFF, 32'h3300_0000, 32'h3F80_0000, 3'b000);
    step("far_shift_sticky",   32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 3'b000);
    step("flags_clear_again",  32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/converter.md
Name: converter

Overview:
- Single-precision (IEEE-754 binary32) floating-point adder/subtractor with a registered result.
- Adds operands A and B (subtraction is done by giving B a negative sign) and registers the result plus status flags every clock.
- Serves as the add stage of the floating-point unit, next to the multiplier.

Parameters:
- XLEN, 32, operand/result width; only 32 (binary32) is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- A  input  XLEN  operand A, binary32
- B  input  XLEN  operand B, binary32
- result  output  XLEN  registered A+B, binary32
- overflow  output  1  registered; the sum rounded to infinity
- underflow  output  1  registered; a nonzero sum was flushed to zero
- exception  output  1  registered; NaN input or invalid operation (Inf + -Inf)

Behaviour:
- Reset: rst high clears result, overflow, underflow and exception to 0 immediately, without waiting for a clock edge. The first capture happens on the first rising clk edge after rst is released.
- Latency and throughput:
  - A and B are sampled on each rising clk edge; the outputs reflect that pair after the same edge, so latency is 1 cycle.
  - A new operand pair is accepted every cycle. There is no handshake; outputs hold between edges.
- Unpacking: sign = bit 31, exp = bits 30:23, frac = bits 22:0. Significand = {1,frac} when exp != 0.
- Denormal inputs (exp=0) are treated as signed zero (flush-to-zero); this sets no flag.
- Datapath:
  1. Swap the operands so the larger magnitude is first; compare exp, then significand.
  2. Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits. A shift of 26 or more reduces it to sticky only.
  3. Equal signs: add the significands. A carry-out shifts right 1 and increments exp.
  4. Different signs: subtract the smaller from the larger, then left-normalize with a leading-zero count, decrementing exp.
  5. Result sign is the sign of the larger-magnitude operand.
- Rounding is round-to-nearest-even. A mantissa carry from rounding renormalizes and increments exp.
- Special cases:
  - Either input NaN (exp=255, frac!=0): result = 0x7FC00000, exception=1.
  - Inf + (-Inf): result = 0x7FC00000, exception=1.
  - Inf + finite, or Inf + same-sign Inf: result = that Inf; no flags.
  - Exact cancellation (including +0 + -0): result = +0 (0x00000000).
  - -0 + -0: result = -0 (0x80000000).
  - Zero + x: result = x bit-exact (x already flushed if denormal).
- Range limits:
  - Final exp >= 255: result = signed Inf, overflow=1.
  - Final exp <= 0 with nonzero magnitude: result = signed zero, underflow=1.
- Flags are mutually exclusive per cycle and are recomputed every cycle; they are not sticky.
- The arithmetic is purely combinational ahead of one output register bank; there are no other internal states.

Test Plan:
- Reset: assert rst mid-operation with outputs nonzero -> result=0 and all flags 0 at once, before any clk edge; the first edge after release loads the current A+B.
- Same-sign add with carry:
  - A=0x404CCCCC (3.2), B=0x40866666 (4.2) -> result 0x40ECCCCC (~7.4) after one edge, flags 0.
  - A=0x4171999A (15.1), B=0x40133333 (2.3) -> 0x418B3333 (~17.4).
- Mixed-sign subtraction with normalization:
  - A=0xBF000000 (-0.5), B=0x40CCCCCC (6.4) -> 0x40BCCCCC (~5.9).
  - A=0xC28C3EFA, B=0xC1F1999A (two negatives) -> negative sum within 0.5 ulp of the exact sum, flags 0.
  - A=0x4034B4B5, B=0xBF70F0F1 -> positive sum within 0.5 ulp of the exact sum.
- Cancellation and zeros:
  - A=0x40490FDB, B=0xC0490FDB -> 0x00000000.
  - A=0x80000000, B=0x80000000 -> 0x80000000.
- Overflow and special values:
  - A=B=0x7F7FFFFF -> 0x7F800000, overflow=1.
  - A=0x7F800000, B=0xFF800000 -> 0x7FC00000, exception=1.
  - A=0x7FC00001, B=0x3F800000 -> 0x7FC00000, exception=1.
- Underflow and streaming:
  - A=0x00800001, B=0x80800000 -> 0x00000000, underflow=1.
  - Back-to-back pairs on consecutive edges -> each result appears exactly one cycle after its operands.
